// File: rtl/i2c_packet_buffer.sv
// Parses I2C listener bytes into tagged ADDR/DATA/END entries and queues them
// in a show-ahead FIFO for a host reader; optional 7-bit address filter.
module i2c_packet_buffer #(
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = 4,
  parameter bit         FILTER_EN  = 1'b0,
  parameter logic [6:0] MATCH_ADDR = 7'h50
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [8:0]       byte_in,
  input  logic             byte_ready,
  input  logic             sop,
  input  logic             eot,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [10:0]      rd_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   level,
  output logic             overflow,
  output logic             in_txn
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_SKIP} state_e;

  typedef struct packed {
    logic [1:0] tag;
    logic [7:0] data;
    logic       flag;
  } entry_t;

  localparam logic [1:0] TAG_ADDR = 2'b01;
  localparam logic [1:0] TAG_DATA = 2'b10;
  localparam logic [1:0] TAG_END  = 2'b11;

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             in_txn_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             ovf_q;
  entry_t           mem [DEPTH];

  logic   addr_hit, push, wr, pop, ovf_set;
  entry_t push_ent;

  assign addr_hit = !FILTER_EN || (byte_in[8:2] == MATCH_ADDR);

  // Push decode mirrors the FSM priority eot > sop > byte_ready.
  always_comb begin
    push     = 1'b0;
    push_ent = '0;
    case (state_q)
      S_ADDR: if (!eot && !sop && byte_ready && addr_hit) begin
        push     = 1'b1;
        push_ent = '{TAG_ADDR, byte_in[8:1], byte_in[0]};
      end
      S_DATA: begin
        if (eot) begin
          push     = 1'b1;
          push_ent = '{TAG_END, cnt_q, 1'b0};
        end else if (sop) begin
          push     = 1'b1;
          push_ent = '{TAG_END, cnt_q, 1'b1};
        end else if (byte_ready) begin
          push     = 1'b1;
          push_ent = '{TAG_DATA, byte_in[8:1], byte_in[0]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      in_txn_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (!eot && sop) begin
          state_q  <= S_ADDR;
          in_txn_q <= 1'b1;
        end
        S_ADDR: begin
          if (eot) begin
            state_q  <= S_IDLE;
            in_txn_q <= 1'b0;
          end else if (!sop && byte_ready) begin
            state_q <= addr_hit ? S_DATA : S_SKIP;
            if (addr_hit) cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (eot) begin
            state_q  <= S_IDLE;
            in_txn_q <= 1'b0;
          end else if (sop) begin
            state_q <= S_ADDR;
          end else if (byte_ready && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SKIP: begin
          if (eot) begin
            state_q  <= S_IDLE;
            in_txn_q <= 1'b0;
          end else if (sop) begin
            state_q <= S_ADDR;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          in_txn_q <= 1'b0;
        end
      endcase
    end
  end

  // When full, a same-cycle pop frees the slot the push lands in.
  assign pop     = rd_en && !empty;
  assign wr      = push && (!full || rd_en);
  assign ovf_set = push && full && !rd_en;

  always_ff @(posedge sysclk) begin
    if (wr) mem[wr_ptr_q] <= push_ent;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr, pop})
        2'b10:   level_q <= level_q + (PTR_W+1)'(1);
        2'b01:   level_q <= level_q - (PTR_W+1)'(1);
        default: ;
      endcase
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign empty    = (level_q == '0);
  assign full     = (level_q == (PTR_W+1)'(DEPTH));
  assign level    = level_q;
  assign overflow = ovf_q;
  assign in_txn   = in_txn_q;
  assign rd_data  = empty ? '0 : mem[rd_ptr_q];

endmodule
